// File: rtl/snake_matrix_renderer.sv
// Builds an 8x8 snake/apple bitmap from the body RAM and swaps it into a display
// buffer that a free-running row scanner multiplexes onto the LED matrix.
module snake_matrix_renderer #(
  parameter int SCAN_DIV = 1000,
  parameter int POS_W    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_req,
  input  logic [POS_W-1:0] i_snake_size,
  input  logic [POS_W-1:0] i_apple_pos,
  input  logic             i_show_apple,
  output logic             o_rd_en,
  output logic [POS_W-1:0] o_rd_addr,
  input  logic [POS_W-1:0] i_rd_data,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_overlap,
  output logic [7:0]       o_row_sel,
  output logic [7:0]       o_col_data
);

  // state   | meaning
  // S_IDLE  | waiting for i_frame_req, inputs latched on acceptance
  // S_CLEAR | shadow and overlap cleared, index reset
  // S_FETCH | one RAM read per cycle, returned data ORed into shadow
  // S_DRAIN | capture data for the last address
  // S_APPLE | optionally OR the apple into shadow
  // S_SWAP  | shadow copied to display, frame_done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_APPLE, S_SWAP
  } state_t;

  localparam int CELLS = 1 << POS_W;
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t             r_state, w_state_nxt;
  logic [POS_W-1:0]   r_size, r_apple, r_idx;
  logic               r_show, r_rd_vld, r_overlap;
  logic [CELLS-1:0]   r_shadow, r_display;
  logic [DIV_W-1:0]   r_div;
  logic [2:0]         r_row;
  logic [7:0]         r_row_sel, r_col_data;

  logic               w_rd_en, w_last, w_div_tc;
  logic [2:0]         w_row_nxt;

  assign w_rd_en = (r_state == S_FETCH);
  assign w_last  = (r_idx == (r_size - POS_W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_req) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = (r_size != '0) ? S_FETCH : S_APPLE;
      S_FETCH: if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_APPLE;
      S_APPLE: w_state_nxt = S_SWAP;
      S_SWAP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM data lags the read strobe by one cycle, so r_rd_vld marks when to merge it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_size    <= '0;
      r_apple   <= '0;
      r_show    <= 1'b0;
      r_idx     <= '0;
      r_rd_vld  <= 1'b0;
      r_overlap <= 1'b0;
      r_shadow  <= '0;
      r_display <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (i_frame_req) begin
            r_size  <= i_snake_size;
            r_apple <= i_apple_pos;
            r_show  <= i_show_apple;
          end
        end
        S_CLEAR: begin
          r_shadow  <= '0;
          r_overlap <= 1'b0;
          r_idx     <= '0;
        end
        S_FETCH: r_idx <= r_idx + POS_W'(1);
        default: ;
      endcase
      if (r_rd_vld) begin
        r_shadow[i_rd_data] <= 1'b1;
        if (r_shadow[i_rd_data]) r_overlap <= 1'b1;
      end
      if (r_state == S_APPLE && r_show) r_shadow[r_apple] <= 1'b1;
      if (r_state == S_SWAP) r_display <= r_shadow;
    end
  end

  assign w_div_tc  = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_row_nxt = w_div_tc ? r_row + 3'd1 : r_row;

  // col_data reloads every clock so a swap shows up without waiting for the row to change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div      <= '0;
      r_row      <= '0;
      r_row_sel  <= 8'b0000_0001;
      r_col_data <= '0;
    end else begin
      r_div      <= w_div_tc ? '0 : r_div + DIV_W'(1);
      r_row      <= w_row_nxt;
      r_row_sel  <= 8'b0000_0001 << w_row_nxt;
      r_col_data <= r_display[{w_row_nxt, 3'b000} +: 8];
    end
  end

  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = r_idx;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = (r_state == S_SWAP);
  assign o_overlap    = r_overlap;
  assign o_row_sel    = r_row_sel;
  assign o_col_data   = r_col_data;

endmodule
